// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter (ALU/MEM round-robin) with pending-write scoreboard
// Grants one writeback per cycle, registers it onto rf_*, and tracks reserved destinations.
module regfile_wb_arbiter #(
    parameter int N_REG = 16,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [DW-1:0]    alu_data,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  logic [4:0]       mem_rd,
    input  logic [DW-1:0]    mem_data,
    output logic             mem_ready,
    input  logic             rsv_valid,
    input  logic [4:0]       rsv_rd,
    output logic             rsv_ready,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    output logic             hz_rs,
    output logic             hz_rt,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [DW-1:0]    rf_data,
    output logic             busy,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_MEM = 1'b1
    } rr_t;

    rr_t              r_rr;
    rr_t              w_rr_next;
    logic [N_REG-1:0] r_pending;
    logic [N_REG-1:0] w_pend_next;
    logic             r_rf_we;
    logic [4:0]       r_rf_rd;
    logic [DW-1:0]    r_rf_data;
    logic [CNT_W-1:0] r_conflict_cnt;

    logic             w_alu_grant;
    logic             w_mem_grant;
    logic             w_both_valid;
    logic [4:0]       w_wr_rd;
    logic [DW-1:0]    w_wr_data;
    logic             w_wr_en;
    logic             w_rsv_ready;
    logic             w_rsv_set;

    function automatic logic in_range(input logic [4:0] a);
        return (a != 5'd0) && (32'(a) < 32'(N_REG));
    endfunction

    // Register 0 and out-of-range addresses always read as not pending.
    function automatic logic pend_lookup(input logic [N_REG-1:0] vec, input logic [4:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < N_REG; i++) begin
            if (a == 5'(i)) begin
                hit = vec[i];
            end
        end
        return hit;
    endfunction

    always_comb begin
        w_both_valid = alu_valid && mem_valid;
        w_alu_grant  = alu_valid && (!mem_valid || (r_rr == RR_ALU));
        w_mem_grant  = mem_valid && (!alu_valid || (r_rr == RR_MEM));
        w_rr_next    = r_rr;
        if (w_both_valid) begin
            w_rr_next = (r_rr == RR_ALU) ? RR_MEM : RR_ALU;
        end
    end

    always_comb begin
        w_wr_rd   = w_mem_grant ? mem_rd   : alu_rd;
        w_wr_data = w_mem_grant ? mem_data : alu_data;
        w_wr_en   = (w_alu_grant || w_mem_grant) && in_range(w_wr_rd);
    end

    // Reservation sees the registered bits, so a same-cycle write does not unblock it.
    always_comb begin
        w_rsv_ready = rsv_valid && !pend_lookup(r_pending, rsv_rd);
        w_rsv_set   = w_rsv_ready && in_range(rsv_rd);
    end

    // Clear for the granted write first, then set for the new reservation.
    always_comb begin
        w_pend_next = r_pending;
        for (int i = 1; i < N_REG; i++) begin
            if (w_wr_en && (w_wr_rd == 5'(i))) begin
                w_pend_next[i] = 1'b0;
            end
            if (w_rsv_set && (rsv_rd == 5'(i))) begin
                w_pend_next[i] = 1'b1;
            end
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr           <= RR_ALU;
            r_pending      <= '0;
            r_rf_we        <= 1'b0;
            r_rf_rd        <= 5'd0;
            r_rf_data      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_rr      <= w_rr_next;
            r_pending <= w_pend_next;
            r_rf_we   <= w_wr_en;
            if (w_wr_en) begin
                r_rf_rd   <= w_wr_rd;
                r_rf_data <= w_wr_data;
            end
            if (w_both_valid && (r_conflict_cnt != {CNT_W{1'b1}})) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign alu_ready    = w_alu_grant;
    assign mem_ready    = w_mem_grant;
    assign rsv_ready    = w_rsv_ready;
    assign hz_rs        = pend_lookup(r_pending, rs);
    assign hz_rt        = pend_lookup(r_pending, rt);
    assign busy         = |r_pending;
    assign rf_we        = r_rf_we;
    assign rf_rd        = r_rf_rd;
    assign rf_data      = r_rf_data;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
// Directed scenarios then randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;
    localparam int N_REG = 16;
    localparam int DW    = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alu_valid = 1'b0, mem_valid = 1'b0, rsv_valid = 1'b0;
    logic [4:0]       alu_rd = '0, mem_rd = '0, rsv_rd = '0, rs = '0, rt = '0;
    logic [DW-1:0]    alu_data = '0, mem_data = '0;
    logic             alu_ready, mem_ready, rsv_ready, hz_rs, hz_rt, rf_we, busy;
    logic [4:0]       rf_rd;
    logic [DW-1:0]    rf_data;
    logic [CNT_W-1:0] conflict_cnt;

    regfile_wb_arbiter #(.N_REG(N_REG), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
        .rs(rs), .rt(rt), .hz_rs(hz_rs), .hz_rt(hz_rt),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [4:0]    rd;
        logic [DW-1:0] data;
        int            cnt;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;

    bit            m_pend[32];
    int            m_favor_mem;
    logic [4:0]    m_rd;
    logic [DW-1:0] m_data;
    int            m_cnt;
    bit            m_alu_g, m_mem_g;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit writable(input int r);
        return (r >= 1) && (r < N_REG);
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_favor_mem = 0;
        m_rd = '0;
        m_data = '0;
        m_cnt = 0;
        m_alu_g = 1'b0;
        m_mem_g = 1'b0;
    endtask

    // Called right after a negedge with inputs applied; predicts this cycle and the next edge.
    task automatic cycle();
        bit            e_alu, e_mem, e_rsv, e_busy;
        int            r;
        logic [DW-1:0] d;
        exp_t          e;
        #1;
        e_alu  = alu_valid && (!mem_valid || m_favor_mem == 0);
        e_mem  = mem_valid && (!alu_valid || m_favor_mem == 1);
        e_rsv  = rsv_valid && !m_pend[rsv_rd];
        e_busy = 1'b0;
        foreach (m_pend[i]) if (m_pend[i]) e_busy = 1'b1;
        chk("alu_ready", 64'(alu_ready), 64'(e_alu));
        chk("mem_ready", 64'(mem_ready), 64'(e_mem));
        chk("rsv_ready", 64'(rsv_ready), 64'(e_rsv));
        chk("hz_rs", 64'(hz_rs), 64'(m_pend[rs]));
        chk("hz_rt", 64'(hz_rt), 64'(m_pend[rt]));
        chk("busy", 64'(busy), 64'(e_busy));
        e.we = 1'b0;
        if (e_alu || e_mem) begin
            r = e_mem ? int'(mem_rd) : int'(alu_rd);
            d = e_mem ? mem_data : alu_data;
            if (writable(r)) begin
                e.we   = 1'b1;
                m_rd   = 5'(r);
                m_data = d;
                m_pend[r] = 1'b0;
            end
        end
        if (alu_valid && mem_valid) begin
            m_favor_mem = 1 - m_favor_mem;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        if (e_rsv && writable(int'(rsv_rd))) m_pend[rsv_rd] = 1'b1;
        e.rd   = m_rd;
        e.data = m_data;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
        m_alu_g = e_alu;
        m_mem_g = e_mem;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("rf_we", 64'(rf_we), 64'(e.we));
            chk("rf_rd", 64'(rf_rd), 64'(e.rd));
            chk("rf_data", 64'(rf_data), 64'(e.data));
            chk("conflict_cnt", 64'(conflict_cnt), 64'(e.cnt));
        end
    end

    // Asserted mid-cycle: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rsv_valid = 1'b0;
        sb_q.delete();
        model_reset();
        #1;
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_rd", 64'(rf_rd), 64'd0);
        chk("rst_rf_data", 64'(rf_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hz_rs", 64'(hz_rs), 64'd0);
        chk("rst_hz_rt", 64'(hz_rt), 64'd0);
        chk("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drop_granted();
        if (m_alu_g) alu_valid = 1'b0;
        if (m_mem_g) mem_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Single ALU write
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        cycle(); drop_granted();
        cycle(); cycle();

        // Contested requesters held until granted
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_0001;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h2222_0002;
        for (int i = 0; i < 4; i++) begin
            cycle(); drop_granted();
        end

        // Reservation, WAW refusal, clear by MEM write
        rsv_valid = 1'b1; rsv_rd = 5'd5; rs = 5'd5; rt = 5'd6;
        cycle();
        cycle();
        rsv_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h5555_AAAA;
        cycle(); drop_granted();
        cycle();

        // Reserve while a write to the same pending register is granted
        rsv_valid = 1'b1; rsv_rd = 5'd9; cycle();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0909_0909;
        cycle(); drop_granted(); rsv_valid = 1'b0;
        cycle();

        // Register 0 and out-of-range destinations
        rsv_valid = 1'b1; rsv_rd = 5'd4; cycle(); rsv_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hABCD_0000;
        cycle(); drop_granted();
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'hABCD_0014;
        cycle(); drop_granted();
        rsv_valid = 1'b1; rsv_rd = 5'd20; rs = 5'd4; rt = 5'd20;
        cycle(); rsv_valid = 1'b0;
        cycle();

        // Mid-cycle reset with a reservation outstanding, then pointer check
        rsv_valid = 1'b1; rsv_rd = 5'd7; cycle(); rsv_valid = 1'b0;
        rs = 5'd7; cycle();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h8888_8888;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hAAAA_0010;
        for (int i = 0; i < 3; i++) begin
            cycle(); drop_granted();
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!alu_valid && $urandom_range(0, 99) < 45) begin
                alu_valid = 1'b1; alu_rd = 5'($urandom_range(0, 19)); alu_data = $urandom;
            end
            if (!mem_valid && $urandom_range(0, 99) < 45) begin
                mem_valid = 1'b1; mem_rd = 5'($urandom_range(0, 19)); mem_data = $urandom;
            end
            rsv_valid = ($urandom_range(0, 99) < 35);
            rsv_rd = 5'($urandom_range(0, 17));
            rs = 5'($urandom_range(0, 31));
            rt = 5'($urandom_range(0, 31));
            cycle();
            drop_granted();
            if (n % 1000 == 999) do_reset();
        end

        alu_valid = 1'b0; mem_valid = 1'b0; rsv_valid = 1'b0;
        cycle();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
